i2c_write_sequencer: RTL and testbench

- Single-master I2C write-transaction controller; generates SCL/SDA for START, 7-bit address + W, ACK checks, N data bytes, STOP.
- Sits between a byte-producer (valid/ready) and the I2C pads; drives the same scl/sda lines the raw bus-pattern monitor decodes.
- Open-drain is modelled as a level output: 1 = released/high, 0 = pulled low.

---
 rtl/i2c_write_sequencer.sv | 172 +++++++++++++++++
 tb/tb_i2c_write_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_write_sequencer.sv
// Single-master I2C write controller: START, address+W, ACK checks, N data bytes, STOP.
// SCL/SDA are level outputs where 1 means released and 0 means pulled low.
module i2c_write_sequencer #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [3:0] nbytes,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       sda_in,
  output logic       scl_out,
  output logic       sda_out,
  output logic       busy,
  output logic       done,
  output logic       nack
);

  typedef enum logic [2:0] {
    StIdle, StStart, StAddr, StAddrAck, StLoad, StData, StDataAck, StStop
  } state_t;

  state_t      state;
  logic [7:0]  div;
  logic [1:0]  qtr;
  logic [2:0]  bitcnt;
  logic [3:0]  bytecnt;
  logic [3:0]  nbytes_q;
  logic [6:0]  addr_q;
  logic [7:0]  shreg;
  logic        ack_bit;
  logic        tick;
  logic        last_byte;

  assign tick      = (div == 8'(CLK_DIV - 1));
  assign last_byte = (state == StAddrAck) ? (nbytes_q == 4'd0) : (bytecnt + 4'd1 == nbytes_q);

  // Pin levels {scl, sda} for a given state, quarter and data bit.
  function automatic logic [1:0] pins(state_t st, logic [1:0] q, logic b);
    case (st)
      StIdle:               pins = 2'b11;
      StStart:              pins = (q == 2'd0) ? 2'b11 : (q == 2'd1) ? 2'b10 : 2'b00;
      StAddr, StData:       pins = {q[1], b};
      StAddrAck, StDataAck: pins = {q[1], 1'b1};
      StLoad:               pins = 2'b00;
      StStop:               pins = (q == 2'd0) ? 2'b00 : (q == 2'd1) ? 2'b10 : 2'b11;
      default:              pins = 2'b11;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= StIdle;
      div      <= 8'd0;
      qtr      <= 2'd0;
      bitcnt   <= 3'd0;
      bytecnt  <= 4'd0;
      nbytes_q <= 4'd0;
      addr_q   <= 7'd0;
      shreg    <= 8'd0;
      ack_bit  <= 1'b0;
      scl_out  <= 1'b1;
      sda_out  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      nack     <= 1'b0;
      wr_ready <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != StIdle && state != StLoad) div <= tick ? 8'd0 : div + 8'd1;
      case (state)
        StIdle: begin
          if (start) begin
            addr_q             <= addr;
            nbytes_q           <= nbytes;
            nack               <= 1'b0;
            busy               <= 1'b1;
            bytecnt            <= 4'd0;
            div                <= 8'd0;
            qtr                <= 2'd0;
            state              <= StStart;
            {scl_out, sda_out} <= pins(StStart, 2'd0, 1'b1);
          end
        end
        StStart: begin
          if (tick) begin
            if (qtr == 2'd2) begin
              state              <= StAddr;
              qtr                <= 2'd0;
              bitcnt             <= 3'd0;
              shreg              <= {addr_q, 1'b0};
              {scl_out, sda_out} <= pins(StAddr, 2'd0, addr_q[6]);
            end else begin
              qtr                <= qtr + 2'd1;
              {scl_out, sda_out} <= pins(StStart, qtr + 2'd1, 1'b1);
            end
          end
        end
        StAddr, StData: begin
          if (tick) begin
            if (qtr == 2'd3) begin
              qtr <= 2'd0;
              if (bitcnt == 3'd7) begin
                state              <= (state == StAddr) ? StAddrAck : StDataAck;
                {scl_out, sda_out} <= pins(StAddrAck, 2'd0, 1'b1);
              end else begin
                bitcnt             <= bitcnt + 3'd1;
                shreg              <= {shreg[6:0], 1'b0};
                {scl_out, sda_out} <= pins(state, 2'd0, shreg[6]);
              end
            end else begin
              qtr                <= qtr + 2'd1;
              {scl_out, sda_out} <= pins(state, qtr + 2'd1, shreg[7]);
            end
          end
        end
        StAddrAck, StDataAck: begin
          if (tick) begin
            if (qtr == 2'd3) begin
              qtr <= 2'd0;
              if (state == StDataAck) bytecnt <= bytecnt + 4'd1;
              if (ack_bit || last_byte) begin
                if (ack_bit) nack <= 1'b1;
                state              <= StStop;
                {scl_out, sda_out} <= pins(StStop, 2'd0, 1'b1);
              end else begin
                state              <= StLoad;
                wr_ready           <= 1'b1;
                {scl_out, sda_out} <= pins(StLoad, 2'd0, 1'b0);
              end
            end else begin
              // ACK is sampled at the tick ending the SCL-high quarter Q2
              if (qtr == 2'd2) ack_bit <= sda_in;
              qtr                <= qtr + 2'd1;
              {scl_out, sda_out} <= pins(state, qtr + 2'd1, 1'b1);
            end
          end
        end
        StLoad: begin
          div <= 8'd0;
          if (wr_valid) begin
            wr_ready           <= 1'b0;
            shreg              <= wr_data;
            bitcnt             <= 3'd0;
            qtr                <= 2'd0;
            state              <= StData;
            {scl_out, sda_out} <= pins(StData, 2'd0, wr_data[7]);
          end
        end
        StStop: begin
          if (tick) begin
            if (qtr == 2'd2) begin
              state              <= StIdle;
              busy               <= 1'b0;
              done               <= 1'b1;
              qtr                <= 2'd0;
              {scl_out, sda_out} <= pins(StIdle, 2'd0, 1'b1);
            end else begin
              qtr                <= qtr + 2'd1;
              {scl_out, sda_out} <= pins(StStop, qtr + 2'd1, 1'b1);
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Randomized bench for i2c_write_sequencer: a bus-level monitor/slave and byte producer
// feed a transaction-level model of bytes, ACKs, handshakes and transaction length.
module tb_i2c_write_sequencer;

  localparam int unsigned CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset, start, wr_valid, wr_ready, sda_in, scl_out, sda_out, busy, done, nack;
  logic [6:0] addr;
  logic [3:0] nbytes;
  logic [7:0] wr_data;
  logic       slave_sda;

  // Open-drain wired-AND of master and slave
  assign sda_in = sda_out & slave_sda;

  always #5 clk = ~clk;

  i2c_write_sequencer #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .nbytes(nbytes),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .sda_in(sda_in),
    .scl_out(scl_out), .sda_out(sda_out), .busy(busy), .done(done), .nack(nack)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transaction set-up, written by the main process only
  logic [7:0] data_a[17];
  int         delay_a[17];
  int         nak_frame_g = -1;
  int         txn_id = 0;

  // Monitor/producer state, written by the bus process only
  int         seen_id, cyc, hs, load_cyc, scl_hi_load, starts, stops, done_cnt, mon_n;
  int         bitpos, frame, pidx, delay_cnt, t_busy, t_done;
  logic [7:0] mon_bytes[32];
  logic [7:0] cur;
  logic       in_txn, offered, prev_scl, prev_sda;

  initial begin
    seen_id = 0; cyc = 0; hs = 0; load_cyc = 0; scl_hi_load = 0; starts = 0; stops = 0;
    done_cnt = 0; mon_n = 0; bitpos = 0; frame = 0; pidx = 0; delay_cnt = 0;
    t_busy = -1; t_done = -1; cur = 8'h00; in_txn = 1'b0; offered = 1'b0;
    prev_scl = 1'b1; prev_sda = 1'b1; slave_sda = 1'b1; wr_valid = 1'b0; wr_data = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (txn_id != seen_id) begin
        seen_id = txn_id; hs = 0; load_cyc = 0; scl_hi_load = 0; starts = 0; stops = 0;
        done_cnt = 0; mon_n = 0; in_txn = 1'b0; bitpos = 0; frame = 0; cur = 8'h00;
        pidx = 0; delay_cnt = delay_a[0]; offered = 1'b0; slave_sda = 1'b1;
        t_busy = -1; t_done = -1;
      end
      // Producer: an offer made while wr_ready was high is taken at the next edge
      if (offered) begin
        hs++;
        if (pidx < 16) pidx++;
        delay_cnt = delay_a[pidx];
        offered   = 1'b0;
      end
      if (wr_ready === 1'b1) begin
        load_cyc++;
        if (scl_out) scl_hi_load++;
        if (delay_cnt > 0) begin
          delay_cnt--;
          wr_valid = 1'b0;
        end else begin
          wr_valid = 1'b1;
          wr_data  = data_a[pidx];
          offered  = 1'b1;
        end
      end else begin
        wr_valid = 1'($urandom_range(0, 1));
        wr_data  = 8'($urandom);
      end
      if (busy && t_busy < 0) t_busy = cyc;
      if (done) begin
        done_cnt++;
        if (t_done < 0) t_done = cyc;
      end
      // Bus monitor and ACK-driving slave
      if (prev_scl && scl_out && prev_sda && !sda_out) begin
        starts++; in_txn = 1'b1; bitpos = 0; frame = 0; cur = 8'h00;
      end else if (prev_scl && scl_out && !prev_sda && sda_out) begin
        stops++; in_txn = 1'b0;
      end else if (in_txn && !prev_scl && scl_out) begin
        if (bitpos < 8) begin
          cur = {cur[6:0], sda_out};
          bitpos++;
        end else if (bitpos == 8) begin
          if (mon_n < 32) mon_bytes[mon_n] = cur;
          mon_n++;
          bitpos = 9;
        end
      end else if (in_txn && prev_scl && !scl_out) begin
        if (bitpos == 8) begin
          slave_sda = (frame == nak_frame_g);
        end else if (bitpos == 9) begin
          slave_sda = 1'b1; bitpos = 0; frame++; cur = 8'h00;
        end
      end
      prev_scl = scl_out;
      prev_sda = sda_out;
    end
  end

  task automatic run_txn(input logic [6:0] a, input int nb, input int nak, input bit poke);
    int       nsent, exp_load, exp_len, lim;
    bit       exp_nack;
    logic [7:0] e;
    nak_frame_g = nak;
    @(negedge clk);
    txn_id++;
    addr   = a;
    nbytes = 4'(nb);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    addr   = 7'($urandom);
    nbytes = 4'($urandom);
    check_val("busy_rise", 32'(busy), 32'd1);
    check_val("nack_clear", 32'(nack), 32'd0);
    lim = 0;
    while (!done && lim < 20000) begin
      @(negedge clk);
      lim++;
      start = (poke && lim == 30);
    end
    start = 1'b0;
    check_val("done_seen", 32'(done), 32'd1);
    check_val("busy_at_done", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);

    if (nak == 0) nsent = 0;
    else if (nak >= 1 && nak <= nb) nsent = nak;
    else nsent = nb;
    exp_nack = (nak >= 0 && nak <= nb);
    exp_load = 0;
    for (int i = 0; i < nsent; i++) exp_load += delay_a[i] + 1;
    exp_len = int'(CLK_DIV) * (42 + 36 * nsent) + exp_load;

    check_val("length", 32'(t_done - t_busy), 32'(exp_len));
    check_val("starts", 32'(starts), 32'd1);
    check_val("stops", 32'(stops), 32'd1);
    check_val("byte_count", 32'(mon_n), 32'(nsent + 1));
    for (int i = 0; i <= nsent && i < mon_n && i < 32; i++) begin
      if (i == 0) e = {a, 1'b0};
      else e = data_a[i-1];
      check_val($sformatf("byte%0d", i), 32'(mon_bytes[i]), 32'(e));
    end
    check_val("handshakes", 32'(hs), 32'(nsent));
    check_val("load_cycles", 32'(load_cyc), 32'(exp_load));
    check_val("scl_high_in_load", 32'(scl_hi_load), 32'd0);
    check_val("nack", 32'(nack), 32'(exp_nack));
    check_val("done_pulses", 32'(done_cnt), 32'd1);
    check_val("idle_bus", 32'({scl_out, sda_out, busy, wr_ready}), 32'b1100);
  endtask

  task automatic fill(input int nb, input int max_delay);
    for (int i = 0; i < 17; i++) begin
      data_a[i]  = 8'($urandom);
      delay_a[i] = (i < nb) ? int'($urandom_range(0, max_delay)) : 0;
    end
  endtask

  initial begin
    int lim, nb, nak;
    reset = 1'b1; start = 1'b0; addr = 7'd0; nbytes = 4'd0;
    fill(0, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_scl", 32'(scl_out), 32'd1);
    check_val("rst_sda", 32'(sda_out), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_nack", 32'(nack), 32'd0);
    check_val("rst_wr_ready", 32'(wr_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Address only, all ACKs low
    fill(0, 0);
    run_txn(7'h50, 0, -1, 1'b0);
    // One byte presented immediately
    fill(1, 0);
    data_a[0] = 8'hA5;
    run_txn(7'h50, 1, -1, 1'b0);
    // Three bytes with a long producer stall before the second
    fill(3, 0);
    data_a[0] = 8'h11; data_a[1] = 8'h22; data_a[2] = 8'h33;
    delay_a[1] = 50;
    run_txn(7'h3C, 3, -1, 1'b0);
    // Address NACK, then a data NACK on the first of three bytes
    fill(2, 3);
    run_txn(7'h21, 2, 0, 1'b0);
    fill(3, 3);
    run_txn(7'h12, 3, 1, 1'b0);
    // Start requests while busy must be ignored
    fill(2, 2);
    run_txn(7'h6B, 2, -1, 1'b1);
    // Maximum byte count
    fill(15, 1);
    run_txn(7'h7F, 15, -1, 1'b0);

    // Reset during bit 4 of the first data byte
    fill(3, 0);
    nak_frame_g = -1;
    @(negedge clk);
    txn_id++;
    addr = 7'h55; nbytes = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lim = 0;
    while (!(frame == 1 && bitpos == 4 && !scl_out) && lim < 5000) begin
      @(negedge clk);
      lim++;
    end
    check_val("reached_data_bit4", 32'(lim < 5000), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_val("async_rst_scl", 32'(scl_out), 32'd1);
    check_val("async_rst_sda", 32'(sda_out), 32'd1);
    check_val("async_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    fill(2, 2);
    run_txn(7'h2A, 2, -1, 1'b0);

    // Randomized transactions
    for (int t = 0; t < 16; t++) begin
      nb = int'($urandom_range(0, 4));
      fill(nb, 6);
      nak = ($urandom_range(0, 9) < 6) ? -1 : int'($urandom_range(0, nb));
      run_txn(7'($urandom), nb, nak, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
